dec_onehot_skid: RTL and testbench



---
 rtl/dec_pkg.sv | 28 ++
 rtl/sat_counter.sv | 32 +++
 rtl/dec_onehot_skid.sv | 120 ++++++++++++
 tb/tb_dec_onehot_skid.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the one-hot decoder with skid buffer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_e (EMPTY/ONE/TWO), default widths, onehot() decode helper.
package dec_pkg;

  localparam int IN_W_DEF  = 3;
  localparam int CNT_W_DEF = 16;

  // onehot() is written once at the widest supported code width.
  // Callers cast the argument up to this width and the result down to theirs.
  localparam int MAX_IN_W  = 8;
  localparam int MAX_OUT_W = 2 ** MAX_IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // O and S empty
    ONE   = 2'd1,  // O full
    TWO   = 2'd2   // O and S full
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
    logic [MAX_OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count reflects an increment one clock after inc_i.
// Backpressure: none; inc_i is sampled every cycle.
// Ports: clk, clr_i (sync clear, wins over inc_i), inc_i, cnt_o[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dec_onehot_skid.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer and delivered-word counter.
// Latency: 1 cycle from input handshake to out_valid; no combinational in_* -> out_* path.
// Backpressure: in_ready is registered and drops only when both O and S are full; full rate with out_ready=1.
// Ports: clk, rst (sync, active high), in_valid/in_code/in_ready, out_valid/out_onehot/out_ready,
//        decode_count (saturating). With DEC_PARITY_CHECK_EN defined: in_par (even parity over
//        in_code) and par_err_count; bad-parity words are consumed but never delivered.
module dec_onehot_skid
  import dec_pkg::*;
#(
  parameter  int IN_W  = IN_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_code,
`ifdef DEC_PARITY_CHECK_EN
  input  logic             in_par,
  output logic [CNT_W-1:0] par_err_count,
`endif
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  input  logic             out_ready,
  output logic [CNT_W-1:0] decode_count
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] o_q, o_d;    // output register, drives out_onehot directly
  logic [OUT_W-1:0] s_q, s_d;    // skid register, only meaningful in TWO
  logic             in_ready_q;
  logic             acc_raw;     // any input handshake
  logic             acc;         // input handshake whose word is to be stored
  logic             drn;
  logic [OUT_W-1:0] word;

  assign acc_raw = in_valid && in_ready_q;
  assign drn     = out_valid && out_ready;
  assign word    = OUT_W'(onehot(MAX_IN_W'(in_code)));

`ifdef DEC_PARITY_CHECK_EN
  logic par_bad;
  assign par_bad = ^{in_code, in_par};
  assign acc     = acc_raw && !par_bad;

  sat_counter #(.W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (acc_raw && par_bad),
    .cnt_o (par_err_count)
  );
`else
  assign acc = acc_raw;
`endif

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d = ONE;
          o_d     = word;
        end
      end
      ONE: begin
        if (acc && drn) begin
          o_d = word;            // replace the departing word in place
        end else if (acc) begin
          state_d = TWO;
          s_d     = word;
        end else if (drn) begin
          state_d = EMPTY;
          o_d     = '0;          // keep out_onehot zero while idle
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen
        if (drn) begin
          state_d = ONE;
          o_d     = s_q;
          s_d     = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        o_d     = '0;
        s_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      o_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      o_q        <= o_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = o_q;

  sat_counter #(.W(CNT_W)) u_dec_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (drn),
    .cnt_o (decode_count)
  );

endmodule

// File: tb/tb_dec_onehot_skid.sv
module tb_dec_onehot_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_code = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, in_ready3, out_valid3;
  logic [7:0]  out_onehot, out_onehot3;
  logic [15:0] decode_count;
  logic [2:0]  decode_count3;
`ifdef DEC_PARITY_CHECK_EN
  logic        in_par = 1'b0;
  logic [15:0] par_err_count;
  logic [2:0]  par_err_count3;
`endif

  always #5 clk = ~clk;

  dec_onehot_skid #(.IN_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
`ifdef DEC_PARITY_CHECK_EN
    .in_par(in_par), .par_err_count(par_err_count),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_onehot(out_onehot),
    .out_ready(out_ready), .decode_count(decode_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  dec_onehot_skid #(.IN_W(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
`ifdef DEC_PARITY_CHECK_EN
    .in_par(in_par), .par_err_count(par_err_count3),
`endif
    .in_ready(in_ready3), .out_valid(out_valid3), .out_onehot(out_onehot3),
    .out_ready(out_ready), .decode_count(decode_count3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a 2-deep FIFO of accepted codes plus plain counters.
  int q[$];
  int m_cnt  = 0;
  int m_perr = 0;

  typedef struct {
    bit         rs;
    bit         v;
    logic [2:0] c;
    bit         r;
    bit         ev;
    logic [7:0] eoh;
    bit         eir;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic tick();
    bit m_acc, m_drn, bad;
    logic [7:0] exp_oh;
    m_drn = (q.size() > 0) && out_ready;
    m_acc = in_valid && (q.size() < 2);
    bad   = 1'b0;
`ifdef DEC_PARITY_CHECK_EN
    bad   = ^{in_code, in_par};
`endif
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_perr = 0;
    end else begin
      if (m_drn) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (m_acc) begin
        if (bad) m_perr++;
        else     q.push_back(int'(in_code));
      end
    end
    @(posedge clk);
    #1;
    exp_oh = (q.size() > 0) ? 8'(1 << q[0]) : 8'h00;
    check("out_valid",     out_valid,     q.size() > 0);
    check("out_onehot",    out_onehot,    exp_oh);
    check("in_ready",      in_ready,      q.size() < 2);
    check("decode_count",  decode_count,  sat(m_cnt, 65535));
    check("out_onehot3",   out_onehot3,   exp_oh);
    check("decode_count3", decode_count3, sat(m_cnt, 7));
`ifdef DEC_PARITY_CHECK_EN
    check("par_err_count",  par_err_count,  sat(m_perr, 65535));
    check("par_err_count3", par_err_count3, sat(m_perr, 7));
`endif
  endtask

  function automatic void add(bit rs, bit v, int c, bit r, bit ev, int eoh, bit eir);
    vec_t t;
    t.rs = rs; t.v = v; t.c = c[2:0]; t.r = r;
    t.ev = ev; t.eoh = eoh[7:0]; t.eir = eir;
    tbl.push_back(t);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rst       = tbl[i].rs;
      in_valid  = tbl[i].v;
      in_code   = tbl[i].c;
      out_ready = tbl[i].r;
`ifdef DEC_PARITY_CHECK_EN
      in_par    = ^tbl[i].c;
`endif
      tick();
      check($sformatf("tbl[%0d].out_valid", i),  out_valid,  tbl[i].ev);
      check($sformatf("tbl[%0d].out_onehot", i), out_onehot, tbl[i].eoh);
      check($sformatf("tbl[%0d].in_ready", i),   in_ready,   tbl[i].eir);
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_end, b_end, c_end;
    logic [2:0] c;

    // Sweep: reset, codes 0..7 back to back, then drain.
    add(1, 1, 5, 0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) add(0, 1, i, 1, 1, 1 << i, 1);
    add(0, 0, 0, 1, 0, 8'h00, 1);
    a_end = tbl.size();
    // Backpressure: 5,3 held, then release.
    add(1, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 5, 0, 1, 8'h20, 1);
    add(0, 1, 3, 0, 1, 8'h20, 0);
    add(0, 0, 0, 0, 1, 8'h20, 0);
    add(0, 0, 0, 1, 1, 8'h08, 1);
    add(0, 0, 0, 1, 0, 8'h00, 1);
    b_end = tbl.size();
    // Accept/drain overlap: 1,2,4,6 with out_ready 1,0,1,1 (4 retried while full).
    add(1, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 1, 1, 1, 8'h02, 1);
    add(0, 1, 2, 0, 1, 8'h02, 0);
    add(0, 1, 4, 1, 1, 8'h04, 1);
    add(0, 1, 4, 1, 1, 8'h10, 1);
    add(0, 1, 6, 1, 1, 8'h40, 1);
    add(0, 0, 0, 1, 0, 8'h00, 1);
    c_end = tbl.size();

    run_rows(0, a_end);
    check("sweep_count", decode_count, 16'd8);
    run_rows(a_end, b_end);
    check("backpressure_count", decode_count, 16'd2);
    run_rows(b_end, c_end);
    check("overlap_count", decode_count, 16'd4);

    // Reset while holding two words (7 then 0).
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tick();
    rst = 1'b0; in_valid = 1'b1; in_code = 3'd7;
`ifdef DEC_PARITY_CHECK_EN
    in_par = 1'b1;
`endif
    tick();
    in_code = 3'd0;
`ifdef DEC_PARITY_CHECK_EN
    in_par = 1'b0;
`endif
    tick();
    check("two_full_in_ready", in_ready, 1'b0);
    rst = 1'b1; in_code = 3'd3; tick();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_onehot", out_onehot, 8'h00);
    check("midrst_count", decode_count, 16'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_stale", out_valid, 1'b0);
    end

    // Saturation of the 3-bit counter: 10 transfers.
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c = 3'(i);
      in_code = c;
`ifdef DEC_PARITY_CHECK_EN
      in_par = ^c;
`endif
      tick();
    end
    in_valid = 1'b0; tick();
    check("sat3_count", decode_count3, 3'd7);
    check("sat16_count", decode_count, 16'd10);
    in_valid = 1'b1; tick(); tick();
    in_valid = 1'b0; tick();
    check("sat3_hold", decode_count3, 3'd7);

`ifdef DEC_PARITY_CHECK_EN
    // Bad parity word is consumed without delivery.
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_code = 3'd3; in_par = 1'b1; tick();
    check("par_bad_not_stored", out_valid, 1'b0);
    in_par = 1'b0; tick();
    check("par_good_onehot", out_onehot, 8'h08);
    in_valid = 1'b0; tick();
    check("par_err_count", par_err_count, 16'd1);
    check("par_dec_count", decode_count, 16'd1);
`endif

    // Randomized traffic with occasional resets.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(49) == 0);
      in_valid  = ($urandom_range(3) != 0);
      c         = 3'($urandom_range(7));
      in_code   = c;
      out_ready = ($urandom_range(2) != 0);
`ifdef DEC_PARITY_CHECK_EN
      in_par    = (^c) ^ ($urandom_range(7) == 0);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
